// File: rtl/uart_receiver.sv
// 8N1 serial receiver: two-flop synchroniser, mid-bit sampling FSM,
// byte holding register with valid flag, sticky framing/overrun flags.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state;
    state_t state_n;

    logic [1:0]    sync;
    logic          rxd_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          half_hit;
    logic          bit_hit;

    assign rxd_s = sync[1];

    // Current-state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode from the synchronised line and the cycle counter.
    always_comb begin
        state_n  = state;
        half_hit = (cnt == HALF_LAST);
        bit_hit  = (cnt == BIT_LAST);
        unique case (state)
            IDLE: begin
                if (!rxd_s) state_n = START;
            end
            START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (half_hit) state_n = rxd_s ? IDLE : DATA;
            end
            DATA: begin
                if (bit_hit && bit_idx == 3'd7) state_n = STOP;
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is seen.
                if (bit_hit) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Synchroniser, counters, shifter and the byte/flag holding registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync      <= 2'b11;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sync <= {sync[0], rxd};
            busy <= (state_n != IDLE);

            if (state == IDLE || state_n != state) begin
                cnt <= '0;
            end else if (state == DATA && bit_hit) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end

            if (state == START && state_n == DATA) begin
                bit_idx <= '0;
            end

            if (state == DATA && bit_hit) begin
                shift   <= {rxd_s, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end

            if (rx_ack) begin
                rx_valid  <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end

            // Later assignments win over the ack clears above.
            if (state == STOP && bit_hit) begin
                if (rxd_s) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                    if (rx_valid && !rx_ack) overrun <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: every fall of busy pops one
// expected output snapshot queued when the stimulus was driven.
module tb_uart_receiver;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       f;
        logic       o;
        logic       lat;
        int         st;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic prev_busy = 1'b0;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .reset(reset),
        .rxd(rxd),
        .rx_ack(rx_ack),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic v, input logic f,
                        input logic o, input logic lat);
        exp_t e;
        e.d = d;
        e.v = v;
        e.f = f;
        e.o = o;
        e.lat = lat;
        e.st = cyc;
        q.push_back(e);
    endtask

    // Call right after a posedge; returns on the edge ending the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic [7:0] d, input logic v,
                              input logic f, input logic o);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            #1 rxd = bits[i];
            if (i == 0) push(d, v, f, o, stop);
            repeat (CPB) @(posedge clk);
        end
        #1 rxd = 1'b1;
    endtask

    task automatic ack_pulse();
        @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d,
                           input logic v, input logic f, input logic o,
                           input logic b);
        chk({tag, "_data"}, 32'(rx_data), 32'(d));
        chk({tag, "_valid"}, 32'(rx_valid), 32'(v));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(f));
        chk({tag, "_ovr"}, 32'(overrun), 32'(o));
        chk({tag, "_busy"}, 32'(busy), 32'(b));
    endtask

    // Scoreboard: compare on every end of receiver activity.
    always @(negedge clk) begin
        if (prev_busy && !busy) begin
            if (q.size() == 0) begin
                chk("unexpected_end", 32'(rx_data), 32'hffff_ffff);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_data", 32'(rx_data), 32'(e.d));
                chk("sb_valid", 32'(rx_valid), 32'(e.v));
                chk("sb_ferr", 32'(frame_err), 32'(e.f));
                chk("sb_ovr", 32'(overrun), 32'(e.o));
                if (e.lat) chk("sb_lat", 32'(cyc - e.st), 32'd155);
            end
        end
        prev_busy = busy;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_out("reset", 8'h00, 0, 0, 0, 0);

        // Single byte with latency check.
        @(posedge clk);
        send_frame(8'h55, 1'b1, 8'h55, 1, 0, 0);
        repeat (20) @(posedge clk);
        ack_pulse();
        chk_out("ack55", 8'h55, 0, 0, 0, 0);

        // Back-to-back frames, acked between them.
        @(posedge clk);
        fork
            begin
                send_frame(8'hA3, 1'b1, 8'hA3, 1, 0, 0);
                send_frame(8'h0F, 1'b1, 8'h0F, 1, 0, 0);
            end
            begin
                for (int i = 0; i < 400 && !rx_valid; i++) @(posedge clk);
                chk("b2b_wait", 32'(rx_valid), 32'd1);
                ack_pulse();
            end
        join
        repeat (20) @(posedge clk);
        ack_pulse();

        // Overrun.
        @(posedge clk);
        send_frame(8'h12, 1'b1, 8'h12, 1, 0, 0);
        repeat (10) @(posedge clk);
        send_frame(8'h34, 1'b1, 8'h34, 1, 0, 1);
        repeat (20) @(posedge clk);
        chk_out("ovr", 8'h34, 1, 0, 1, 0);
        ack_pulse();
        chk_out("ovr_ack", 8'h34, 0, 0, 0, 0);

        // Framing error; the low stop bit also trips one rejected start.
        @(posedge clk);
        send_frame(8'hC6, 1'b0, 8'h34, 0, 1, 0);
        push(8'h34, 0, 1, 0, 0);
        repeat (30) @(posedge clk);
        chk_out("ferr", 8'h34, 0, 1, 0, 0);
        ack_pulse();
        chk_out("ferr_ack", 8'h34, 0, 0, 0, 0);

        // Short glitch.
        @(posedge clk);
        #1 rxd = 1'b0;
        push(8'h34, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (30) @(posedge clk);
        chk_out("glitch", 8'h34, 0, 0, 0, 0);

        // Reset mid-DATA, then a clean frame.
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (CPB + 40) @(posedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        rxd = 1'b1;
        push(8'h00, 0, 0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk_out("midreset", 8'h00, 0, 0, 0, 0);
        repeat (10) @(posedge clk);
        send_frame(8'h81, 1'b1, 8'h81, 1, 0, 0);
        repeat (20) @(posedge clk);

        // Ack lands exactly on the stop-sample edge of a new byte.
        fork
            begin
                @(posedge clk);
                send_frame(8'h7E, 1'b1, 8'h7E, 1, 0, 0);
            end
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1 rx_ack = 1'b1;
                @(posedge clk);
                #1 rx_ack = 1'b0;
                chk_out("coinc", 8'h7E, 1, 0, 0, 0);
            end
        join
        repeat (20) @(posedge clk);
        ack_pulse();
        chk_out("final", 8'h7E, 0, 0, 0, 0);

        repeat (20) @(posedge clk);
        chk("q_left", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
